// File: rtl/arm_multicycle_ctrl.sv
// arm_multicycle_ctrl
// Multicycle controller for the ARMv4-subset core. A registered FSM sequences
// one shared memory port and one shared ALU over several cycles per
// instruction, with a memory wait-state handshake, optional extended
// data-processing ops, early abort on a failed condition and an
// illegal-instruction strobe.
//
// Ports:
//   clk          clock
//   reset        asynchronous, active-high reset
//   instr        IR[31:12] = {cond, op, funct, rn, rd}
//   alu_flags    {N,Z,C,V} produced by the ALU this cycle
//   mem_ready    memory completes the access this cycle
//   pc_write     PC register enable
//   adr_src      memory address select (0=PC, 1=ALUOut)
//   mem_write    memory write strobe
//   ir_write     IR load enable
//   reg_write    register file write enable
//   result_src   result mux (00=ALUOut, 01=Data, 10=ALUResult)
//   alu_src_a    ALU A select (0=RD1, 1=PC)
//   alu_src_b    ALU B select (00=RD2, 01=ExtImm, 10=const 4)
//   alu_control  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 PASSB
//   imm_src      00 imm8, 01 imm12, 10 branch imm24
//   reg_src      [0]=RA1 from R15, [1]=RA2 from Rd
//   flags        registered NZCV
//   illegal      one-cycle pulse on an unimplemented instruction
module arm_multicycle_ctrl #(
    parameter bit         EXT_OPS    = 1'b1,
    parameter bit         MEM_WAIT   = 1'b1,
    parameter logic [3:0] FLAG_RESET = 4'b0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] instr,
    input  logic [3:0]  alu_flags,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        adr_src,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic [1:0]  result_src,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_control,
    output logic [1:0]  imm_src,
    output logic [1:0]  reg_src,
    output logic [3:0]  flags,
    output logic        illegal
);

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_ORR   = 3'b011;
    localparam logic [2:0] ALU_EOR   = 3'b100;
    localparam logic [2:0] ALU_PASSB = 3'b101;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
        S_MEMWRITE, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
    } state_t;

    state_t      state, state_next;
    logic [3:0]  flags_next;

    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  cmd;
    logic [3:0]  rd;
    logic        s_bit;
    logic        ready;
    logic        cond_pass;
    logic        cmd_legal;
    logic        cmd_test;
    logic        cmd_cv;
    logic [2:0]  cmd_alu;
    logic        pc_write_raw, mem_write_raw, ir_write_raw, reg_write_raw, illegal_raw;

    // rn only steers the datapath register file, never the control flow
    logic        unused_rn;

    assign cond      = instr[19:16];
    assign op        = instr[15:14];
    assign funct     = instr[13:8];
    assign cmd       = funct[4:1];
    assign s_bit     = funct[0];
    assign rd        = instr[3:0];
    assign unused_rn = ^instr[7:4];

    // Without wait states the memory is assumed to answer every cycle
    assign ready = MEM_WAIT ? mem_ready : 1'b1;

    // Condition check against the registered flags; 1111 never executes
    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'b0000: cond_pass = flags[2];
            4'b0001: cond_pass = ~flags[2];
            4'b0010: cond_pass = flags[1];
            4'b0011: cond_pass = ~flags[1];
            4'b0100: cond_pass = flags[3];
            4'b0101: cond_pass = ~flags[3];
            4'b0110: cond_pass = flags[0];
            4'b0111: cond_pass = ~flags[0];
            4'b1000: cond_pass = flags[1] & ~flags[2];
            4'b1001: cond_pass = ~flags[1] | flags[2];
            4'b1010: cond_pass = (flags[3] == flags[0]);
            4'b1011: cond_pass = (flags[3] != flags[0]);
            4'b1100: cond_pass = ~flags[2] & (flags[3] == flags[0]);
            4'b1101: cond_pass = flags[2] | (flags[3] != flags[0]);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Data-processing command decode: ALU op, legality, compare-only ops
    // (which skip writeback) and whether C/V come from the adder
    always_comb begin
        cmd_legal = 1'b0;
        cmd_test  = 1'b0;
        cmd_cv    = 1'b0;
        cmd_alu   = ALU_ADD;
        case (cmd)
            4'b0100: begin cmd_legal = 1'b1; cmd_alu = ALU_ADD; cmd_cv = 1'b1; end
            4'b0010: begin cmd_legal = 1'b1; cmd_alu = ALU_SUB; cmd_cv = 1'b1; end
            4'b0000: begin cmd_legal = 1'b1; cmd_alu = ALU_AND; end
            4'b1100: begin cmd_legal = 1'b1; cmd_alu = ALU_ORR; end
            4'b0001: begin cmd_legal = EXT_OPS; cmd_alu = ALU_EOR; end
            4'b1101: begin cmd_legal = EXT_OPS; cmd_alu = ALU_PASSB; end
            4'b1010: begin cmd_legal = EXT_OPS; cmd_alu = ALU_SUB; cmd_cv = 1'b1; cmd_test = 1'b1; end
            4'b1000: begin cmd_legal = EXT_OPS; cmd_alu = ALU_AND; cmd_test = 1'b1; end
            default: begin cmd_legal = 1'b0; end
        endcase
    end

    // Immediate and register-port selects follow the instruction class in
    // every state so the datapath sees stable operands throughout
    always_comb begin
        imm_src = 2'b00;
        reg_src = 2'b00;
        case (op)
            2'b01: begin
                imm_src = 2'b01;
                reg_src = funct[0] ? 2'b00 : 2'b10;
            end
            2'b10: begin
                imm_src = 2'b10;
                reg_src = 2'b01;
            end
            default: begin
                imm_src = 2'b00;
                reg_src = 2'b00;
            end
        endcase
    end

    // Flag update at the end of EXECR/EXECI: compares always update N/Z,
    // other ops only with S; C/V only come from the adder/subtractor
    always_comb begin
        flags_next = flags;
        if ((state == S_EXECR || state == S_EXECI) && (s_bit || cmd_test)) begin
            flags_next[3:2] = alu_flags[3:2];
            if (cmd_cv) begin
                flags_next[1:0] = alu_flags[1:0];
            end
        end
    end

    // State and flag registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
            flags <= FLAG_RESET;
        end else begin
            state <= state_next;
            flags <= flags_next;
        end
    end

    // Next-state and datapath control for each FSM state
    always_comb begin
        state_next    = state;
        pc_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        illegal_raw   = 1'b0;
        adr_src       = 1'b0;
        result_src    = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_control   = ALU_ADD;
        case (state)
            S_FETCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (ready) begin
                    ir_write_raw = 1'b1;
                    pc_write_raw = 1'b1;
                    state_next   = S_DECODE;
                end
            end
            S_DECODE: begin
                // PC+4 computed again here so that R15 reads as PC+8
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (!cond_pass) begin
                    state_next = S_FETCH;
                end else begin
                    case (op)
                        2'b01: state_next = S_MEMADR;
                        2'b10: state_next = S_BRANCH;
                        2'b00: begin
                            if (!cmd_legal) begin
                                illegal_raw = 1'b1;
                                state_next  = S_FETCH;
                            end else begin
                                state_next = funct[5] ? S_EXECI : S_EXECR;
                            end
                        end
                        default: begin
                            illegal_raw = 1'b1;
                            state_next  = S_FETCH;
                        end
                    endcase
                end
            end
            S_MEMADR: begin
                alu_src_b  = 2'b01;
                state_next = funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (ready) begin
                    state_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                result_src    = 2'b01;
                reg_write_raw = 1'b1;
                pc_write_raw  = (rd == 4'hF);
                state_next    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src       = 1'b1;
                mem_write_raw = 1'b1;
                if (ready) begin
                    state_next = S_FETCH;
                end
            end
            S_EXECR, S_EXECI: begin
                alu_src_b   = (state == S_EXECI) ? 2'b01 : 2'b00;
                alu_control = cmd_alu;
                state_next  = cmd_test ? S_FETCH : S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                pc_write_raw  = (rd == 4'hF);
                state_next    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_b    = 2'b01;
                result_src   = 2'b10;
                pc_write_raw = 1'b1;
                state_next   = S_FETCH;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // Strobes are masked combinationally so nothing writes while reset is high
    assign pc_write  = pc_write_raw  & ~reset;
    assign mem_write = mem_write_raw & ~reset;
    assign ir_write  = ir_write_raw  & ~reset;
    assign reg_write = reg_write_raw & ~reset;
    assign illegal   = illegal_raw   & ~reset;

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// tb_arm_multicycle_ctrl
// Directed bench for arm_multicycle_ctrl. dut1 uses the default parameters;
// dut2 uses EXT_OPS=0, MEM_WAIT=0, FLAG_RESET=1010 and shares the stimulus
// inputs but has its own reset, so each instance runs while the other is
// held in reset.
module tb_arm_multicycle_ctrl;

    localparam logic [19:0] W_ADD   = 20'hE2802;
    localparam logic [19:0] W_SUBS  = 20'hE0523;
    localparam logic [19:0] W_ADDEQ = 20'h02802;
    localparam logic [19:0] W_ADDNE = 20'h12802;
    localparam logic [19:0] W_ADDLT = 20'hB2802;
    localparam logic [19:0] W_ADDGE = 20'hA2802;
    localparam logic [19:0] W_LDR   = 20'hE5901;
    localparam logic [19:0] W_STR   = 20'hE5801;
    localparam logic [19:0] W_CMP   = 20'hE3510;
    localparam logic [19:0] W_TST   = 20'hE3010;
    localparam logic [19:0] W_MOVS  = 20'hE3B00;
    localparam logic [19:0] W_EORPC = 20'hE020F;
    localparam logic [19:0] W_B     = 20'hEAFFF;
    localparam logic [19:0] W_OP11  = 20'hEC000;
    localparam logic [19:0] W_RSB   = 20'hE0600;

    logic        clk = 1'b0;
    logic        reset, reset2;
    logic [19:0] instr;
    logic [3:0]  alu_flags;
    logic        mem_ready;

    logic        pc_write1, adr_src1, mem_write1, ir_write1, reg_write1, alu_src_a1, illegal1;
    logic [1:0]  result_src1, alu_src_b1, imm_src1, reg_src1;
    logic [2:0]  alu_control1;
    logic [3:0]  flags1;

    logic        pc_write2, adr_src2, mem_write2, ir_write2, reg_write2, alu_src_a2, illegal2;
    logic [1:0]  result_src2, alu_src_b2, imm_src2, reg_src2;
    logic [2:0]  alu_control2;
    logic [3:0]  flags2;

    logic [17:0] obs1, obs2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    arm_multicycle_ctrl dut1 (
        .clk(clk), .reset(reset), .instr(instr), .alu_flags(alu_flags), .mem_ready(mem_ready),
        .pc_write(pc_write1), .adr_src(adr_src1), .mem_write(mem_write1), .ir_write(ir_write1),
        .reg_write(reg_write1), .result_src(result_src1), .alu_src_a(alu_src_a1),
        .alu_src_b(alu_src_b1), .alu_control(alu_control1), .imm_src(imm_src1),
        .reg_src(reg_src1), .flags(flags1), .illegal(illegal1)
    );

    arm_multicycle_ctrl #(.EXT_OPS(1'b0), .MEM_WAIT(1'b0), .FLAG_RESET(4'b1010)) dut2 (
        .clk(clk), .reset(reset2), .instr(instr), .alu_flags(alu_flags), .mem_ready(mem_ready),
        .pc_write(pc_write2), .adr_src(adr_src2), .mem_write(mem_write2), .ir_write(ir_write2),
        .reg_write(reg_write2), .result_src(result_src2), .alu_src_a(alu_src_a2),
        .alu_src_b(alu_src_b2), .alu_control(alu_control2), .imm_src(imm_src2),
        .reg_src(reg_src2), .flags(flags2), .illegal(illegal2)
    );

    assign obs1 = {pc_write1, adr_src1, mem_write1, ir_write1, reg_write1, result_src1,
                   alu_src_a1, alu_src_b1, alu_control1, imm_src1, reg_src1, illegal1};
    assign obs2 = {pc_write2, adr_src2, mem_write2, ir_write2, reg_write2, result_src2,
                   alu_src_a2, alu_src_b2, alu_control2, imm_src2, reg_src2, illegal2};

    // Expected control word, packed in the same field order as obs1/obs2
    function automatic logic [17:0] ctl(input logic pcw, input logic adr, input logic mw,
                                        input logic irw, input logic rw, input logic [1:0] rs,
                                        input logic asa, input logic [1:0] asb,
                                        input logic [2:0] ac, input logic [1:0] is,
                                        input logic [1:0] rsrc, input logic ill);
        return {pcw, adr, mw, irw, rw, rs, asa, asb, ac, is, rsrc, ill};
    endfunction

    // Expected control word for each FSM state, straight from the state table
    function automatic logic [17:0] e_fetch(input logic rdy, input logic [1:0] is, input logic [1:0] rs);
        return ctl(rdy, 1'b0, 1'b0, rdy, 1'b0, 2'b10, 1'b1, 2'b10, 3'b000, is, rs, 1'b0);
    endfunction
    function automatic logic [17:0] e_decode(input logic [1:0] is, input logic [1:0] rs, input logic ill);
        return ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b10, 3'b000, is, rs, ill);
    endfunction
    function automatic logic [17:0] e_memadr(input logic [1:0] rs);
        return ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 3'b000, 2'b01, rs, 1'b0);
    endfunction
    function automatic logic [17:0] e_memrd();
        return ctl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 2'b01, 2'b00, 1'b0);
    endfunction
    function automatic logic [17:0] e_memwr();
        return ctl(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 2'b01, 2'b10, 1'b0);
    endfunction
    function automatic logic [17:0] e_memwb();
        return ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 3'b000, 2'b01, 2'b00, 1'b0);
    endfunction
    function automatic logic [17:0] e_exec(input logic imm, input logic [2:0] ac);
        return ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, imm ? 2'b01 : 2'b00, ac, 2'b00, 2'b00, 1'b0);
    endfunction
    function automatic logic [17:0] e_aluwb(input logic pcw);
        return ctl(pcw, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 3'b000, 2'b00, 2'b00, 1'b0);
    endfunction
    function automatic logic [17:0] e_branch();
        return ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 2'b01, 3'b000, 2'b10, 2'b01, 1'b0);
    endfunction

    // Advance one clock, then drive this cycle's inputs and let them settle
    task automatic applyStimulus(input logic [19:0] i, input logic [3:0] f, input logic r);
        @(posedge clk);
        #1;
        instr     = i;
        alu_flags = f;
        mem_ready = r;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [17:0] observed, input logic [17:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Directed sequence: dut1 first, then dut2
    initial begin
        reset     = 1'b1;
        reset2    = 1'b1;
        instr     = W_ADD;
        alu_flags = 4'b0000;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("reset_outs", obs1, e_fetch(1'b0, 2'b00, 2'b00));
        checkOutput("reset_flags", {14'd0, flags1}, 18'd0);

        // ADD R2,R0,#5 with flags offered on the ALU but S=0
        @(posedge clk); #1; reset = 1'b0; alu_flags = 4'b1111; #1;
        checkOutput("add_fetch", obs1, e_fetch(1'b1, 2'b00, 2'b00));
        applyStimulus(W_ADD, 4'b1111, 1'b1);
        checkOutput("add_decode", obs1, e_decode(2'b00, 2'b00, 1'b0));
        applyStimulus(W_ADD, 4'b1111, 1'b1);
        checkOutput("add_execi", obs1, e_exec(1'b1, 3'b000));
        applyStimulus(W_ADD, 4'b1111, 1'b1);
        checkOutput("add_aluwb", obs1, e_aluwb(1'b0));
        checkOutput("add_flags", {14'd0, flags1}, 18'd0);

        // SUBS R3,R2,R2 sets Z and C
        applyStimulus(W_SUBS, 4'b0110, 1'b1);
        applyStimulus(W_SUBS, 4'b0110, 1'b1);
        applyStimulus(W_SUBS, 4'b0110, 1'b1);
        checkOutput("subs_execr", obs1, e_exec(1'b0, 3'b001));
        applyStimulus(W_SUBS, 4'b0000, 1'b1);
        checkOutput("subs_flags", {14'd0, flags1}, {14'd0, 4'b0110});

        // ADDEQ executes on Z=1
        applyStimulus(W_ADDEQ, 4'b0000, 1'b1);
        applyStimulus(W_ADDEQ, 4'b0000, 1'b1);
        applyStimulus(W_ADDEQ, 4'b0000, 1'b1);
        checkOutput("addeq_execi", obs1, e_exec(1'b1, 3'b000));
        applyStimulus(W_ADDEQ, 4'b0000, 1'b1);
        checkOutput("addeq_aluwb", obs1, e_aluwb(1'b0));

        // ADDNE aborts after DECODE
        applyStimulus(W_ADDNE, 4'b0000, 1'b1);
        applyStimulus(W_ADDNE, 4'b0000, 1'b1);
        checkOutput("addne_decode", obs1, e_decode(2'b00, 2'b00, 1'b0));
        applyStimulus(W_LDR, 4'b0000, 1'b1);
        checkOutput("addne_then_fetch", obs1, e_fetch(1'b1, 2'b01, 2'b00));

        // LDR with three wait states in MEMREAD
        applyStimulus(W_LDR, 4'b0000, 1'b1);
        checkOutput("ldr_decode", obs1, e_decode(2'b01, 2'b00, 1'b0));
        applyStimulus(W_LDR, 4'b0000, 1'b1);
        checkOutput("ldr_memadr", obs1, e_memadr(2'b00));
        for (int k = 0; k < 3; k++) begin
            applyStimulus(W_LDR, 4'b0000, 1'b0);
            checkOutput("ldr_memread_wait", obs1, e_memrd());
        end
        applyStimulus(W_LDR, 4'b0000, 1'b1);
        checkOutput("ldr_memread_done", obs1, e_memrd());
        applyStimulus(W_LDR, 4'b0000, 1'b1);
        checkOutput("ldr_memwb", obs1, e_memwb());
        applyStimulus(W_STR, 4'b0000, 1'b1);
        checkOutput("ldr_then_fetch", obs1, e_fetch(1'b1, 2'b01, 2'b10));

        // STR with two wait states, then a FETCH that waits one cycle
        applyStimulus(W_STR, 4'b0000, 1'b1);
        applyStimulus(W_STR, 4'b0000, 1'b1);
        checkOutput("str_memadr", obs1, e_memadr(2'b10));
        applyStimulus(W_STR, 4'b0000, 1'b0);
        checkOutput("str_memwrite_1", obs1, e_memwr());
        applyStimulus(W_STR, 4'b0000, 1'b0);
        checkOutput("str_memwrite_2", obs1, e_memwr());
        applyStimulus(W_STR, 4'b0000, 1'b1);
        checkOutput("str_memwrite_3", obs1, e_memwr());
        applyStimulus(W_CMP, 4'b0000, 1'b0);
        checkOutput("str_fetch_hold", obs1, e_fetch(1'b0, 2'b00, 2'b00));
        applyStimulus(W_CMP, 4'b0100, 1'b1);
        checkOutput("cmp_fetch", obs1, e_fetch(1'b1, 2'b00, 2'b00));

        // CMP R1,#7 writes all four flags and skips writeback
        applyStimulus(W_CMP, 4'b0100, 1'b1);
        applyStimulus(W_CMP, 4'b0100, 1'b1);
        checkOutput("cmp_execi", obs1, e_exec(1'b1, 3'b001));
        applyStimulus(W_TST, 4'b1011, 1'b1);
        checkOutput("cmp_to_fetch", obs1, e_fetch(1'b1, 2'b00, 2'b00));
        checkOutput("cmp_flags", {14'd0, flags1}, {14'd0, 4'b0100});

        // TST without S still writes N/Z but keeps C/V
        applyStimulus(W_TST, 4'b1011, 1'b1);
        applyStimulus(W_TST, 4'b1011, 1'b1);
        checkOutput("tst_execi", obs1, e_exec(1'b1, 3'b010));
        applyStimulus(W_MOVS, 4'b0111, 1'b1);
        checkOutput("tst_to_fetch", obs1, e_fetch(1'b1, 2'b00, 2'b00));
        checkOutput("tst_flags", {14'd0, flags1}, {14'd0, 4'b1000});

        // MOVS writes N/Z only
        applyStimulus(W_MOVS, 4'b0111, 1'b1);
        applyStimulus(W_MOVS, 4'b0111, 1'b1);
        checkOutput("movs_execi", obs1, e_exec(1'b1, 3'b101));
        applyStimulus(W_MOVS, 4'b0000, 1'b1);
        checkOutput("movs_aluwb", obs1, e_aluwb(1'b0));
        checkOutput("movs_flags", {14'd0, flags1}, {14'd0, 4'b0100});

        // EOR into R15 also writes the PC
        applyStimulus(W_EORPC, 4'b0000, 1'b1);
        applyStimulus(W_EORPC, 4'b0000, 1'b1);
        applyStimulus(W_EORPC, 4'b0000, 1'b1);
        checkOutput("eor_execr", obs1, e_exec(1'b0, 3'b100));
        applyStimulus(W_EORPC, 4'b0000, 1'b1);
        checkOutput("eor_aluwb_pc", obs1, e_aluwb(1'b1));

        // Branch backwards
        applyStimulus(W_B, 4'b0000, 1'b1);
        checkOutput("b_fetch", obs1, e_fetch(1'b1, 2'b10, 2'b01));
        applyStimulus(W_B, 4'b0000, 1'b1);
        applyStimulus(W_B, 4'b0000, 1'b1);
        checkOutput("b_branch", obs1, e_branch());

        // op=11 and an unsupported DP cmd are both illegal
        applyStimulus(W_OP11, 4'b0000, 1'b1);
        applyStimulus(W_OP11, 4'b0000, 1'b1);
        checkOutput("op11_illegal", obs1, e_decode(2'b00, 2'b00, 1'b1));
        applyStimulus(W_RSB, 4'b0000, 1'b1);
        checkOutput("op11_then_fetch", obs1, e_fetch(1'b1, 2'b00, 2'b00));
        applyStimulus(W_RSB, 4'b0000, 1'b1);
        checkOutput("rsb_illegal", obs1, e_decode(2'b00, 2'b00, 1'b1));
        applyStimulus(W_STR, 4'b0000, 1'b1);
        checkOutput("rsb_then_fetch", obs1, e_fetch(1'b1, 2'b01, 2'b10));
        checkOutput("illegal_flags", {14'd0, flags1}, {14'd0, 4'b0100});

        // Reset in the middle of a stalled STR
        applyStimulus(W_STR, 4'b0000, 1'b1);
        applyStimulus(W_STR, 4'b0000, 1'b1);
        applyStimulus(W_STR, 4'b0000, 1'b0);
        checkOutput("rst_str_memwrite", obs1, e_memwr());
        #2; reset = 1'b1; #1;
        checkOutput("rst_async_outs", obs1, e_fetch(1'b0, 2'b01, 2'b10));
        checkOutput("rst_flags", {14'd0, flags1}, 18'd0);
        @(posedge clk); #1; reset = 1'b0; mem_ready = 1'b0; #1;
        checkOutput("rst_release_fetch", obs1, e_fetch(1'b0, 2'b01, 2'b10));
        reset = 1'b1;

        // dut2: EXT_OPS=0, MEM_WAIT=0, FLAG_RESET=1010
        #1;
        checkOutput("d2_reset_flags", {14'd0, flags2}, {14'd0, 4'b1010});
        @(posedge clk); #1; reset2 = 1'b0; instr = W_CMP; alu_flags = 4'b0100; mem_ready = 1'b0; #1;
        checkOutput("d2_fetch_nowait", obs2, e_fetch(1'b1, 2'b00, 2'b00));
        applyStimulus(W_CMP, 4'b0100, 1'b0);
        checkOutput("d2_cmp_illegal", obs2, e_decode(2'b00, 2'b00, 1'b1));
        applyStimulus(W_ADDLT, 4'b0000, 1'b0);
        checkOutput("d2_cmp_then_fetch", obs2, e_fetch(1'b1, 2'b00, 2'b00));
        checkOutput("d2_flags_kept", {14'd0, flags2}, {14'd0, 4'b1010});

        // LT passes and GE fails with N=1, V=0
        applyStimulus(W_ADDLT, 4'b0000, 1'b0);
        applyStimulus(W_ADDLT, 4'b0000, 1'b0);
        checkOutput("d2_addlt_execi", obs2, e_exec(1'b1, 3'b000));
        applyStimulus(W_ADDGE, 4'b0000, 1'b0);
        applyStimulus(W_ADDGE, 4'b0000, 1'b0);
        applyStimulus(W_ADDGE, 4'b0000, 1'b0);
        checkOutput("d2_addge_decode", obs2, e_decode(2'b00, 2'b00, 1'b0));
        applyStimulus(W_LDR, 4'b0000, 1'b0);
        checkOutput("d2_addge_skip", obs2, e_fetch(1'b1, 2'b01, 2'b00));

        // LDR ignores mem_ready when wait states are disabled
        applyStimulus(W_LDR, 4'b0000, 1'b0);
        applyStimulus(W_LDR, 4'b0000, 1'b0);
        checkOutput("d2_memadr", obs2, e_memadr(2'b00));
        applyStimulus(W_LDR, 4'b0000, 1'b0);
        checkOutput("d2_memread", obs2, e_memrd());
        applyStimulus(W_LDR, 4'b0000, 1'b0);
        checkOutput("d2_memwb_nowait", obs2, e_memwb());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a stuck run
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
